// File: rtl/step_motor_pkg.sv
// Shared definitions for the stepper sequencer: mode encodings, coil phase table
// and the phase-index stepping rule.
package step_motor_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE = 2'b00,
    MODE_FULL = 2'b01,
    MODE_HALF = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Entry i is the {BY,BX,AY,AX} pattern for phase index i.
  localparam logic [7:0][3:0] PHASE_TBL = {
    4'b1001, 4'b1000, 4'b1010, 4'b0010,
    4'b0110, 4'b0100, 4'b0101, 4'b0001
  };

  // Wave keeps to even (single-coil) indices, full to odd (two-coil) indices;
  // an off-grid start takes a single step to rejoin the grid.
  function automatic logic [2:0] next_idx(input logic [2:0] p, input logic dir,
                                          input mode_e mode);
    logic [2:0] stp;
    case (mode)
      MODE_WAVE: stp = p[0] ? 3'd1 : 3'd2;
      MODE_FULL: stp = p[0] ? 3'd2 : 3'd1;
      default:   stp = 3'd1;
    endcase
    return dir ? p + stp : p - stp;
  endfunction

endpackage

// File: rtl/step_motor_channel.sv
// One stepper channel: command latch, step-rate counter, phase index, coil drive
// and sticky fault handling.
module step_motor_channel
  import step_motor_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [1:0]        cmd_mode,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              fault_n,
  input  logic              fault_clr,
  output logic [3:0]        coil,
  output logic              bridge_en,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [STEP_W-1:0] steps_left
);

  logic [1:0]       fsync;
  logic [2:0]       idx, idx_nxt;
  logic [DIV_W-1:0] cnt, period_q;
  logic             dir_q;
  mode_e            mode_q;
  logic             flt_act, accept, step_now;

  assign flt_act   = ~fsync[1];
  assign cmd_ready = en & ~busy & ~fault;
  assign accept    = cmd_valid & cmd_ready;
  assign step_now  = busy & (cnt == period_q);
  assign idx_nxt   = next_idx(idx, dir_q, mode_q);

  // Resets to the inactive level so reset release never reports a fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsync <= 2'b11;
    else          fsync <= {fsync[0], fault_n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coil       <= '0;
      bridge_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      steps_left <= '0;
      idx        <= '0;
      cnt        <= '0;
      period_q   <= '0;
      dir_q      <= 1'b0;
      mode_q     <= MODE_WAVE;
    end else begin
      done <= 1'b0;
      if (flt_act) begin
        // Fault outranks any step due this cycle; steps_left keeps the remainder.
        fault     <= 1'b1;
        coil      <= '0;
        bridge_en <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (fault_clr) fault <= 1'b0;
        if (!en || fault) begin
          coil      <= '0;
          bridge_en <= 1'b0;
          busy      <= 1'b0;
        end else begin
          bridge_en <= 1'b1;
          if (accept) begin
            dir_q      <= cmd_dir;
            mode_q     <= mode_e'(cmd_mode);
            period_q   <= cmd_period;
            steps_left <= cmd_steps;
            cnt        <= '0;
            busy       <= (cmd_steps != '0);
            done       <= (cmd_steps == '0);
            coil       <= PHASE_TBL[idx];
          end else if (step_now) begin
            cnt        <= '0;
            idx        <= idx_nxt;
            coil       <= PHASE_TBL[idx_nxt];
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else begin
            // Idle or between steps: hold torque on the current phase.
            coil <= PHASE_TBL[idx];
            if (busy) cnt <= cnt + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/step_motor_sequencer.sv
// Multi-channel stepper phase sequencer; one independent channel per motor port.
module step_motor_sequencer
  import step_motor_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int STEP_W   = 16,
  parameter int DIV_W    = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [CHANNELS-1:0]              en,
  input  logic [CHANNELS-1:0]              cmd_valid,
  output logic [CHANNELS-1:0]              cmd_ready,
  input  logic [CHANNELS-1:0]              cmd_dir,
  input  logic [CHANNELS-1:0][1:0]         cmd_mode,
  input  logic [CHANNELS-1:0][STEP_W-1:0]  cmd_steps,
  input  logic [CHANNELS-1:0][DIV_W-1:0]   cmd_period,
  input  logic [CHANNELS-1:0]              fault_n,
  input  logic [CHANNELS-1:0]              fault_clr,
  output logic [CHANNELS-1:0][3:0]         coil,
  output logic [CHANNELS-1:0]              bridge_en,
  output logic [CHANNELS-1:0]              busy,
  output logic [CHANNELS-1:0]              done,
  output logic [CHANNELS-1:0]              fault,
  output logic [CHANNELS-1:0][STEP_W-1:0]  steps_left
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    step_motor_channel #(.STEP_W(STEP_W), .DIV_W(DIV_W)) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en[gi]),
      .cmd_valid  (cmd_valid[gi]),
      .cmd_ready  (cmd_ready[gi]),
      .cmd_dir    (cmd_dir[gi]),
      .cmd_mode   (cmd_mode[gi]),
      .cmd_steps  (cmd_steps[gi]),
      .cmd_period (cmd_period[gi]),
      .fault_n    (fault_n[gi]),
      .fault_clr  (fault_clr[gi]),
      .coil       (coil[gi]),
      .bridge_en  (bridge_en[gi]),
      .busy       (busy[gi]),
      .done       (done[gi]),
      .fault      (fault[gi]),
      .steps_left (steps_left[gi])
    );
  end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Directed bench for step_motor_sequencer with hand-computed expectations.
module tb_step_motor_sequencer;
  localparam int CH = 4, SW = 16, DW = 16;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [CH-1:0]       en, cmd_valid, cmd_ready, cmd_dir, fault_n, fault_clr;
  logic [CH-1:0]       bridge_en, busy, done, fault;
  logic [CH-1:0][1:0]  cmd_mode;
  logic [CH-1:0][SW-1:0] cmd_steps, steps_left;
  logic [CH-1:0][DW-1:0] cmd_period;
  logic [CH-1:0][3:0]  coil;

  int n_chk = 0, n_fail = 0;

  step_motor_sequencer #(.CHANNELS(CH), .STEP_W(SW), .DIV_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .fault_n(fault_n),
    .fault_clr(fault_clr), .coil(coil), .bridge_en(bridge_en), .busy(busy),
    .done(done), .fault(fault), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int c, input logic [1:0] m, input logic d,
                      input logic [SW-1:0] s, input logic [DW-1:0] p);
    cmd_mode[c] = m; cmd_dir[c] = d; cmd_steps[c] = s; cmd_period[c] = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp1 [8];
    logic [3:0] exp2 [3];
    exp1 = '{4'b0101, 4'b0100, 4'b0110, 4'b0010, 4'b1010, 4'b1000, 4'b1001, 4'b0001};
    exp2 = '{4'b1001, 4'b1010, 4'b0110};

    reset_n = 1'b0; en = '0; cmd_valid = '0; cmd_dir = '0; cmd_mode = '0;
    cmd_steps = '0; cmd_period = '0; fault_n = '1; fault_clr = '0;
    tick(2);
    chk("rst_coil", coil, 0);
    chk("rst_bridge", bridge_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_steps_left", steps_left, 0);
    reset_n = 1'b1; en = 4'hF;
    tick(2);
    chk("ready_after_en", cmd_ready, 4'hF);
    chk("bridge_after_en", bridge_en, 4'hF);

    // Half mode forward, 8 steps, period 3 on ch0.
    load(0, 2'b10, 1'b1, 8, 3);
    cmd_valid[0] = 1'b1; tick(); cmd_valid[0] = 1'b0;
    chk("t1_busy", busy[0], 1);
    chk("t1_sl0", steps_left[0], 8);
    chk("t1_ready_busy", cmd_ready[0], 0);
    for (int k = 0; k < 8; k++) begin
      tick(4);
      chk($sformatf("t1_coil%0d", k), coil[0], exp1[k]);
      chk($sformatf("t1_sl%0d", k), steps_left[0], 7 - k);
      chk($sformatf("t1_done%0d", k), done[0], (k == 7) ? 1 : 0);
    end
    chk("t1_busy_end", busy[0], 0);
    tick();
    chk("t1_done_pulse", done[0], 0);
    chk("t1_ready_back", cmd_ready[0], 1);

    // Full mode reverse from index 0, period 0 on ch2.
    load(2, 2'b01, 1'b0, 3, 0);
    cmd_valid[2] = 1'b1; tick(); cmd_valid[2] = 1'b0;
    chk("t2_busy0", busy[2], 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t2_coil%0d", k), coil[2], exp2[k]);
      chk($sformatf("t2_busy%0d", k), busy[2], (k < 2) ? 1 : 0);
    end
    chk("t2_done", done[2], 1);

    // Long move on ch2, then a zero-step command on ch3 while ch2 is busy.
    load(2, 2'b10, 1'b1, 20, 9);
    cmd_valid[2] = 1'b1; tick();
    load(2, 2'b10, 1'b1, 5, 0);
    load(3, 2'b10, 1'b1, 0, 0);
    cmd_valid[3] = 1'b1;
    chk("t3_ready_mask", cmd_ready[3:2], 2'b10);
    tick();
    chk("t3_ch2_not_reloaded", steps_left[2], 20);
    chk("t3_ch3_no_busy", busy[3], 0);
    chk("t3_ch3_done", done[3], 1);
    cmd_valid[2] = 1'b0; cmd_valid[3] = 1'b0;
    tick();
    chk("t3_ch3_done_once", done[3], 0);
    chk("t3_ch2_busy", busy[2], 1);

    // Fault mid-move on ch0 (index 0), 10 steps period 1.
    load(0, 2'b10, 1'b1, 10, 1);
    cmd_valid[0] = 1'b1; tick(); cmd_valid[0] = 1'b0;
    tick(7);
    chk("t4_sl_pre", steps_left[0], 7);
    fault_n[0] = 1'b0;
    tick();
    chk("t4_step4_coil", coil[0], 4'b0010);
    chk("t4_step4_sl", steps_left[0], 6);
    tick();
    chk("t4_sync_delay", bridge_en[0], 1);
    tick();
    chk("t4_coil_off", coil[0], 0);
    chk("t4_bridge_off", bridge_en[0], 0);
    chk("t4_fault", fault[0], 1);
    chk("t4_busy", busy[0], 0);
    chk("t4_sl_held", steps_left[0], 6);
    chk("t4_no_done", done[0], 0);
    chk("t4_ready", cmd_ready[0], 0);
    fault_clr[0] = 1'b1; tick(); fault_clr[0] = 1'b0;
    chk("t4_clr_ignored", fault[0], 1);
    fault_n[0] = 1'b1;
    tick(2);
    chk("t4_still_fault", fault[0], 1);
    fault_clr[0] = 1'b1; load(0, 2'b10, 1'b1, 1, 0); cmd_valid[0] = 1'b1;
    chk("t4_ready_clr_cycle", cmd_ready[0], 0);
    tick();
    fault_clr[0] = 1'b0; cmd_valid[0] = 1'b0;
    chk("t4_cleared", fault[0], 0);
    chk("t4_cmd_not_taken", busy[0], 0);
    chk("t4_ready_after", cmd_ready[0], 1);

    // en dropped mid-move on ch1, then a new 2-step move from the kept index.
    load(1, 2'b10, 1'b1, 5, 0);
    cmd_valid[1] = 1'b1; tick(); cmd_valid[1] = 1'b0;
    tick(2);
    chk("t5_coil_pre", coil[1], 4'b0100);
    en[1] = 1'b0;
    tick();
    chk("t5_coil_off", coil[1], 0);
    chk("t5_bridge_off", bridge_en[1], 0);
    chk("t5_busy_off", busy[1], 0);
    chk("t5_sl_held", steps_left[1], 3);
    chk("t5_no_done", done[1], 0);
    en[1] = 1'b1; load(1, 2'b10, 1'b1, 2, 0); cmd_valid[1] = 1'b1;
    tick(); cmd_valid[1] = 1'b0;
    chk("t5_sl_new", steps_left[1], 2);
    tick();
    chk("t5_coil_a", coil[1], 4'b0110);
    tick();
    chk("t5_coil_b", coil[1], 4'b0010);
    chk("t5_done", done[1], 1);

    // Asynchronous reset in the middle of the ch2 move.
    chk("t6_busy_pre", busy[2], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_coil", coil, 0);
    chk("t6_busy", busy, 0);
    chk("t6_bridge", bridge_en, 0);
    chk("t6_sl", steps_left[2], 0);
    tick(2);
    reset_n = 1'b1; en = 4'b1010;
    tick();
    chk("t6_ready_en", cmd_ready, 4'b1010);
    load(1, 2'b10, 1'b1, 1, 0);
    cmd_valid[1] = 1'b1; tick(); cmd_valid[1] = 1'b0;
    tick();
    chk("t6_idx0", coil[1], 4'b0101);
    chk("t6_done", done[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/step_motor_sequencer.md
Name: step_motor_sequencer

Overview:
- Multi-channel stepper-motor phase sequencer; replaces the fixed per-port wiring of coil pins (XA/XB/XC/XD, XAB/XCD bridge enables, FAULT input) with generated drive.
- Each channel accepts a move command (step count, direction, step period, mode), steps the four coil outputs through the phase table at the programmed rate, reports progress, and aborts safely on driver FAULT.
- Sits between the bus/register layer and the board motor ports; one channel per motor port.

Parameters:
CHANNELS, 4, number of independent motor channels
STEP_W, 16, width of step count and steps_left
DIV_W, 16, width of step period (clock cycles)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
en  in  CHANNELS  per-channel drive enable
cmd_valid  in  CHANNELS  per-channel command strobe
cmd_ready  out  CHANNELS  channel can accept a command
cmd_dir  in  CHANNELS  1=forward (phase index increments), 0=reverse
cmd_mode  in  2*CHANNELS  00 wave, 01 full, 10 half, 11 reserved (treated as half)
cmd_steps  in  STEP_W*CHANNELS  steps to move
cmd_period  in  DIV_W*CHANNELS  step spacing minus one, in clocks
fault_n  in  CHANNELS  driver FAULT pin, active low, asynchronous
fault_clr  in  CHANNELS  one-cycle pulse, clears sticky fault
coil  out  4*CHANNELS  per channel {BY,BX,AY,AX}
bridge_en  out  CHANNELS  drives XAB and XCD
busy  out  CHANNELS  move in progress
done  out  CHANNELS  one-cycle pulse, move completed normally
fault  out  CHANNELS  sticky fault flag
steps_left  out  STEP_W*CHANNELS  remaining steps of current or aborted move

Behaviour:
- Reset: coil=0, bridge_en=0, busy=0, done=0, fault=0, steps_left=0, phase index=0, period counter=0.
- Phase table (index 0..7, {BY,BX,AY,AX}): 0=0001, 1=0101, 2=0100, 3=0110, 4=0010, 5=1010, 6=1000, 7=1001; index wraps modulo 8.
- Next index: half: p±1. Full: p odd -> p±2, p even -> p±1. Wave: p even -> p±2, p odd -> p±1.
- cmd_ready = en & ~busy & ~fault (combinational). Accept on cmd_valid & cmd_ready: latch dir/mode/period, steps_left<=cmd_steps, counter<=0, busy<=1 if cmd_steps!=0.
- cmd_steps=0: accepted, busy stays 0, done pulses the next cycle.
- Stepping: a step occurs in each cycle where busy & counter==period; otherwise counter increments. On a step: counter<=0, phase advances, coil is registered from the new index on that edge, steps_left decrements.
- Step spacing is period+1 clocks. First step occurs period+1 cycles after the accept edge. period=0 steps every clock.
- Last step (steps_left 1->0): busy<=0, done<=1 for one cycle. cmd_ready rises the cycle after busy falls.
- Idle with en=1 and no fault: coil holds the last phase pattern (holding torque), bridge_en=1.
- en=0: coil=0 and bridge_en=0 on the next edge. Any move is aborted: busy<=0, no done, steps_left holds the remainder. Phase index is retained.
- fault_n passes through a 2-flop synchroniser. Synchronised low: fault<=1, coil<=0, bridge_en<=0, move aborted as for en=0.
- Fault and step in the same cycle: fault wins and the step is not applied.
- fault clears only on fault_clr while synchronised fault_n is high. fault_clr while fault_n is low is ignored. A command presented on the clearing cycle is not accepted; ready rises the next cycle.
- Channels are fully independent. There is no shared arbitration.

Decomposition:
- Package step_motor_pkg: mode encodings (MODE_WAVE/FULL/HALF), 8-entry phase table constant, next-index function.
- One sub-module step_motor_channel: single-channel datapath and control, instantiated CHANNELS times by generate. The top only slices the flattened vectors.

Test Plan:
- Half mode, dir=1, steps=8, period=3, ch0 -> coil 0101,0100,0110,0010,1010,1000,1001,0001 at accept+4,+8,...,+32 cycles; done pulse at accept+32; steps_left 8->0.
- Full mode from index 0, dir=0, steps=3, period=0 -> indices 7,5,3 on consecutive clocks; coil 1001,1010,0110; busy exactly 3 cycles.
- Fault mid-move: steps=10, period=1, fault_n low after 4 steps -> coil=0, bridge_en=0 three clocks later (two sync stages plus one register); fault=1, steps_left=6, no done; cmd_ready=0 until fault_n high plus fault_clr, then cmd_ready=1 the cycle after.
- en dropped mid-move, then re-raised with a new command steps=2 -> first move aborted with remainder held; new move resumes from the retained phase index.
- steps=0 command -> busy never asserted, done one cycle after accept; cmd_valid held high while busy on another channel -> only the ready channel accepts.
- Reset asserted mid-move -> all outputs zero immediately (asynchronously); after release, phase index=0 and cmd_ready follows en.
